serial_adder_ctrl: RTL and testbench

- Sequences a bit-serial N-bit addition through a single 1-bit adder cell, built from two half-adder stages plus a carry register.
- Loads two WIDTH-bit operands on a start handshake, shifts one bit per clock through the cell, and presents a registered Sum/Carry result with a one-cycle Done pulse.
- Serves as the area-minimal arithmetic controller in the datapath, where one shared adder cell replaces a WIDTH-bit parallel adder.

---
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_adder_ctrl: bit-serial WIDTH-bit adder built on one shared 1-bit
// cell (two half adders plus a carry register), with a Start/Done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a Sub port for A - B.
// Revision: 1.0
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             cin;
  logic             sub_in;

  logic s1, c1, s, c2, cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = Sub;
`else
  assign sub_in = 1'b0;
`endif

  // The shared 1-bit cell: two cascaded half adders.
  assign s1   = a_sr[0] ^ b_sr[0];
  assign c1   = a_sr[0] & b_sr[0];
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      cin    <= 1'b0;
      Sum    <= '0;
      Carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry.
            a_sr   <= A;
            b_sr   <= sub_in ? ~B : B;
            cin    <= sub_in;
            sum_sr <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cin    <= cout;
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum   <= {s, sum_sr[WIDTH-1:1]};
            Carry <= cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl: directed plus randomized bench with a cycle-level
// transaction model of the serial adder. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (start),
    .A     (a),
    .B     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub   (sub),
`endif
    .Busy  (busy),
    .Done  (done),
    .Sum   (sum),
    .Carry (carry)
  );

  // Transaction model: an accepted operation yields A+B (or A-B) after W
  // cycles, then one Done cycle; nothing is accepted while busy.
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [W:0] m_res = '0;
  logic [W-1:0] m_sum = '0;
  logic       m_carry = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        {m_carry, m_sum} <= m_res;
        m_done <= 1'b1;
      end
    end else if (start) begin
      m_left <= W;
      if (SUB_EN && sub)
        m_res <= {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else
        m_res <= {1'b0, a} + {1'b0, b};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_busy",  32'(busy),  32'(m_left > 0 || m_done));
      check("model_done",  32'(done),  32'(m_done));
      check("model_sum",   32'(sum),   32'(m_sum));
      check("model_carry", 32'(carry), 32'(m_carry));
    end
  end

  // Pulse Start for one cycle, then wait (bounded) for Done; cyc is the
  // number of cycles from the Start edge to the first Done sample.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, output int cyc);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 4*W) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic op_expect(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic isub, input logic [W-1:0] esum, input logic ecarry);
    int cyc;
    run_op(ia, ib, isub, cyc);
    check({name, "_lat"},   32'(cyc),   32'(W));
    check({name, "_sum"},   32'(sum),   32'(esum));
    check({name, "_carry"}, 32'(carry), 32'(ecarry));
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int last_done;
    int pulses;
    int spurious;

    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sum",   32'(sum),   32'h0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);

    op_expect("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
    op_expect("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op_expect("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // Starts issued in RUN and in DONE must be ignored.
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 4*W) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_done_seen", 32'(done), 32'd1);
    check("ign_sum",   32'(sum),   32'h03);
    check("ign_carry", 32'(carry), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spurious = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done || busy) spurious++;
      @(negedge clk);
    end
    check("ign_no_extra", 32'(spurious), 32'd0);

    // Reset in the middle of a run.
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_sum",   32'(sum),   32'h0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    spurious = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) spurious++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 32'(spurious), 32'd0);
    op_expect("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Start held high: Done every W+2 cycles.
    a = 8'h10; b = 8'h20; start = 1'b1;
    pulses = 0;
    last_done = -1;
    for (int t = 0; t < 5*(W+2) && pulses < 4; t++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_sum", 32'(sum), 32'h30);
        if (last_done >= 0) check("b2b_interval", 32'(t - last_done), 32'(W + 2));
        last_done = t;
        pulses++;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd4);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op_expect("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    op_expect("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    op_expect("sub0_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
`endif

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
